// File: rtl/matrix_pkg.sv
// Shared types and helpers for the LED matrix scan driver.
//   MATRIX_ROWS / MATRIX_COLS : matrix geometry (7 rows x 3 columns)
//   scan_state_t              : scan FSM states
//   row_pattern_t             : one column's row pattern (bit i = row i)
//   col_sel_n()               : active-low one-hot column enable for a column index
//   next_col()                : column index successor, 0 -> 1 -> 2 -> 0
package matrix_pkg;

    localparam int unsigned MATRIX_ROWS = 7;
    localparam int unsigned MATRIX_COLS = 3;
    localparam int unsigned IDX_W       = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHOW  = 2'd1,
        BLANK = 2'd2
    } scan_state_t;

    typedef logic [MATRIX_ROWS-1:0] row_pattern_t;

    localparam logic [MATRIX_COLS-1:0] COLS_OFF = '1;

    // Active-low one-hot enable for column idx.
    function automatic logic [MATRIX_COLS-1:0] col_sel_n(input logic [IDX_W-1:0] idx);
        return ~(MATRIX_COLS'(1) << idx);
    endfunction

    // Next column in scan order, wrapping after the last column.
    function automatic logic [IDX_W-1:0] next_col(input logic [IDX_W-1:0] idx);
        return (idx == IDX_W'(MATRIX_COLS - 1)) ? '0 : idx + IDX_W'(1);
    endfunction

endpackage

// File: rtl/scan_prescaler.sv
// Modulo-N counter pacing the column scan.
//   clock, reset_n : clock and asynchronous active-low reset
//   clear          : synchronous clear to 0 (wins over run)
//   run            : count enable
//   last           : terminal value; the counter wraps last -> 0, so N = last + 1
//   tc_c           : combinational terminal count (run && count == last)
module scan_prescaler #(
    parameter int unsigned W = 16
) (
    input  logic         clock,
    input  logic         reset_n,
    input  logic         clear,
    input  logic         run,
    input  logic [W-1:0] last,
    output logic         tc_c
);

    logic [W-1:0] count;

    assign tc_c = run && (count == last);

    // Counter register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (run) begin
            count <= tc_c ? '0 : count + W'(1);
        end
    end

endmodule

// File: rtl/matrix_scan_driver.sv
// Time-multiplexed scan driver for the 7x3 LED matrix. Lights one column at a
// time with its row pattern; the three column patterns are latched once per
// frame so a frame never mixes data from two input updates.
// Optional build macro: MATRIX_BLANK_EN inserts BLANK_CYCLES dark cycles
// between columns to remove ghosting.
//   clock, reset_n      : clock and asynchronous active-low reset
//   enable              : 1 = scanning, 0 = dark and idle
//   col_2, col_1, col_0 : row patterns for each column
//   rows                : registered active-high row drive
//   column_sel_n        : registered active-low one-hot column enable
//   frame_start         : registered one-cycle pulse when column 0 shows a fresh latch
module matrix_scan_driver
    import matrix_pkg::*;
#(
    parameter int unsigned SCAN_DIV     = 50000,
    parameter int unsigned DIV_W        = 16,
    parameter int unsigned BLANK_CYCLES = 64
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic                   enable,
    input  logic [MATRIX_ROWS-1:0] col_2,
    input  logic [MATRIX_ROWS-1:0] col_1,
    input  logic [MATRIX_ROWS-1:0] col_0,
    output logic [MATRIX_ROWS-1:0] rows,
    output logic [MATRIX_COLS-1:0] column_sel_n,
    output logic                   frame_start
);

`ifdef MATRIX_BLANK_EN
    localparam bit BLANK_EN = 1'b1;
`else
    localparam bit BLANK_EN = 1'b0;
`endif

    localparam logic [DIV_W-1:0] SCAN_LAST  = DIV_W'(SCAN_DIV - 1);
    localparam logic [DIV_W-1:0] BLANK_LAST = DIV_W'(BLANK_CYCLES - 1);

    scan_state_t                    state;
    logic [IDX_W-1:0]               idx;
    row_pattern_t [MATRIX_COLS-1:0] shadow;

    logic             tc_c;
    logic             pre_clear_c;
    logic             pre_run_c;
    logic [DIV_W-1:0] pre_last_c;
    logic [IDX_W-1:0] idx_nxt_c;
    logic             wrap_c;

    // Prescaler held at 0 while idle or disabled; BLANK reuses it with its own length.
    assign pre_clear_c = !enable || (state == IDLE);
    assign pre_run_c   = (state != IDLE);
    assign pre_last_c  = (state == BLANK) ? BLANK_LAST : SCAN_LAST;

    assign idx_nxt_c = next_col(idx);
    assign wrap_c    = (idx_nxt_c == '0);

    scan_prescaler #(
        .W (DIV_W)
    ) u_prescaler (
        .clock   (clock),
        .reset_n (reset_n),
        .clear   (pre_clear_c),
        .run     (pre_run_c),
        .last    (pre_last_c),
        .tc_c    (tc_c)
    );

    // Scan FSM with registered outputs.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state        <= IDLE;
            idx          <= '0;
            shadow       <= '0;
            rows         <= '0;
            column_sel_n <= COLS_OFF;
            frame_start  <= 1'b0;
        end else if (!enable) begin
            // Abandon the current column immediately; shadow is refreshed on restart.
            state        <= IDLE;
            idx          <= '0;
            rows         <= '0;
            column_sel_n <= COLS_OFF;
            frame_start  <= 1'b0;
        end else begin
            frame_start <= 1'b0;
            case (state)
                IDLE: begin
                    shadow       <= {col_2, col_1, col_0};
                    state        <= SHOW;
                    idx          <= '0;
                    rows         <= col_0;
                    column_sel_n <= col_sel_n(IDX_W'(0));
                    frame_start  <= 1'b1;
                end
                SHOW, BLANK: begin
                    if (tc_c) begin
                        if (BLANK_EN && (state == SHOW)) begin
                            state        <= BLANK;
                            rows         <= '0;
                            column_sel_n <= COLS_OFF;
                        end else begin
                            state        <= SHOW;
                            idx          <= idx_nxt_c;
                            column_sel_n <= col_sel_n(idx_nxt_c);
                            if (wrap_c) begin
                                // New frame: re-latch and show fresh col_0 on the same edge.
                                shadow      <= {col_2, col_1, col_0};
                                rows        <= col_0;
                                frame_start <= 1'b1;
                            end else begin
                                rows <= shadow[idx_nxt_c];
                            end
                        end
                    end
                end
                default: begin
                    state        <= IDLE;
                    rows         <= '0;
                    column_sel_n <= COLS_OFF;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_matrix_scan_driver.sv
// Directed self-checking bench for matrix_scan_driver (SCAN_DIV=4, BLANK_CYCLES=2).
// Expectations follow the MATRIX_BLANK_EN build setting of the bench itself.
module tb_matrix_scan_driver;

    localparam int SCAN_DIV = 4;
`ifdef MATRIX_BLANK_EN
    localparam int NB = 2;
`else
    localparam int NB = 0;
`endif
    localparam int SLOT   = SCAN_DIV + NB;
    localparam int PERIOD = 3 * SLOT;

    logic       clock = 1'b0;
    logic       reset_n = 1'b0;
    logic       enable = 1'b0;
    logic [6:0] col_2 = '0;
    logic [6:0] col_1 = '0;
    logic [6:0] col_0 = '0;
    logic [6:0] rows;
    logic [2:0] column_sel_n;
    logic       frame_start;

    int checks = 0;
    int errors = 0;

    matrix_scan_driver #(
        .SCAN_DIV     (SCAN_DIV),
        .DIV_W        (16),
        .BLANK_CYCLES (2)
    ) dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .enable       (enable),
        .col_2        (col_2),
        .col_1        (col_1),
        .col_0        (col_0),
        .rows         (rows),
        .column_sel_n (column_sel_n),
        .frame_start  (frame_start)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    function automatic logic [2:0] sel_of(input int k);
        case (k)
            0:       return 3'b110;
            1:       return 3'b101;
            default: return 3'b011;
        endcase
    endfunction

    // Return to IDLE, load patterns, enable; leaves the bench just after the lighting edge.
    task automatic restart(input logic [6:0] p2, input logic [6:0] p1, input logic [6:0] p0);
        enable = 1'b0;
        tick();
        col_2  = p2;
        col_1  = p1;
        col_0  = p0;
        enable = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        enable  = 1'b0;
        repeat (3) tick();
        reset_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            checks++;
            if (rows !== 7'h00 || column_sel_n !== 3'b111 || frame_start !== 1'b0) begin
                errors++;
                $display("FAIL reset_idle cyc=%0d: rows=%h sel=%b fs=%b, want 00 111 0",
                         i, rows, column_sel_n, frame_start);
            end
            tick();
        end
    endtask

    task automatic test_scan();
        logic [6:0] er;
        logic [2:0] es;
        logic       ef;
        restart(7'h04, 7'h02, 7'h01);
        for (int f = 0; f < 2; f++) begin
            for (int k = 0; k < 3; k++) begin
                for (int c = 0; c < SLOT; c++) begin
                    er = (c >= SCAN_DIV) ? 7'h00 : (k == 0) ? 7'h01 : (k == 1) ? 7'h02 : 7'h04;
                    es = (c >= SCAN_DIV) ? 3'b111 : sel_of(k);
                    ef = (k == 0 && c == 0);
                    checks++;
                    if (rows !== er || column_sel_n !== es || frame_start !== ef) begin
                        errors++;
                        $display("FAIL scan f%0d k%0d c%0d: rows=%h sel=%b fs=%b, want %h %b %b",
                                 f, k, c, rows, column_sel_n, frame_start, er, es, ef);
                    end
                    tick();
                end
            end
        end
    endtask

    task automatic test_midframe_latch();
        logic [6:0] er;
        logic [2:0] es;
        int         cyc;
        int         last_fs;
        restart(7'h04, 7'h02, 7'h01);
        cyc     = 0;
        last_fs = -1;
        for (int f = 0; f < 3; f++) begin
            for (int k = 0; k < 3; k++) begin
                for (int c = 0; c < SLOT; c++) begin
                    if (c >= SCAN_DIV) er = 7'h00;
                    else if (k == 0)   er = 7'h01;
                    else if (k == 1)   er = (f == 0) ? 7'h02 : 7'h7F;
                    else               er = 7'h04;
                    es = (c >= SCAN_DIV) ? 3'b111 : sel_of(k);
                    checks++;
                    if (rows !== er || column_sel_n !== es) begin
                        errors++;
                        $display("FAIL latch f%0d k%0d c%0d: rows=%h sel=%b, want %h %b",
                                 f, k, c, rows, column_sel_n, er, es);
                    end
                    if (frame_start === 1'b1) begin
                        if (last_fs >= 0) begin
                            checks++;
                            if (cyc - last_fs !== PERIOD) begin
                                errors++;
                                $display("FAIL frame_period: got %0d, want %0d", cyc - last_fs, PERIOD);
                            end
                        end
                        last_fs = cyc;
                    end
                    if (f == 0 && k == 1 && c == 1) col_1 = 7'h7F;
                    cyc++;
                    tick();
                end
            end
        end
        checks++;
        if (last_fs !== 2 * PERIOD) begin
            errors++;
            $display("FAIL last_frame_start: got cycle %0d, want %0d", last_fs, 2 * PERIOD);
        end
    endtask

    task automatic test_enable_drop();
        restart(7'h44, 7'h22, 7'h11);
        repeat (2 * SLOT + 1) tick();
        checks++;
        if (rows !== 7'h44 || column_sel_n !== 3'b011) begin
            errors++;
            $display("FAIL drop_precheck: rows=%h sel=%b, want 44 011", rows, column_sel_n);
        end
        enable = 1'b0;
        tick();
        checks++;
        if (rows !== 7'h00 || column_sel_n !== 3'b111 || frame_start !== 1'b0) begin
            errors++;
            $display("FAIL drop_dark: rows=%h sel=%b fs=%b, want 00 111 0", rows, column_sel_n, frame_start);
        end
        repeat (5) tick();
        checks++;
        if (rows !== 7'h00 || column_sel_n !== 3'b111) begin
            errors++;
            $display("FAIL drop_hold: rows=%h sel=%b, want 00 111", rows, column_sel_n);
        end
        col_0  = 7'h3C;
        enable = 1'b1;
        tick();
        checks++;
        if (rows !== 7'h3C || column_sel_n !== 3'b110 || frame_start !== 1'b1) begin
            errors++;
            $display("FAIL reenable: rows=%h sel=%b fs=%b, want 3c 110 1", rows, column_sel_n, frame_start);
        end
        repeat (SCAN_DIV) tick();
        checks++;
        if (column_sel_n !== ((NB > 0) ? 3'b111 : 3'b101) || frame_start !== 1'b0) begin
            errors++;
            $display("FAIL reenable_advance: sel=%b fs=%b", column_sel_n, frame_start);
        end
    endtask

    task automatic test_async_reset();
        restart(7'h04, 7'h55, 7'h2A);
        repeat (SLOT + 1) tick();
        checks++;
        if (rows !== 7'h55 || column_sel_n !== 3'b101) begin
            errors++;
            $display("FAIL rst_precheck: rows=%h sel=%b, want 55 101", rows, column_sel_n);
        end
        #2;
        reset_n = 1'b0;
        #1;
        checks++;
        if (rows !== 7'h00 || column_sel_n !== 3'b111 || frame_start !== 1'b0) begin
            errors++;
            $display("FAIL rst_async: rows=%h sel=%b fs=%b, want 00 111 0", rows, column_sel_n, frame_start);
        end
        tick();
        checks++;
        if (rows !== 7'h00 || column_sel_n !== 3'b111) begin
            errors++;
            $display("FAIL rst_held: rows=%h sel=%b, want 00 111", rows, column_sel_n);
        end
        @(negedge clock);
        reset_n = 1'b1;
        tick();
        checks++;
        if (rows !== 7'h2A || column_sel_n !== 3'b110 || frame_start !== 1'b1) begin
            errors++;
            $display("FAIL rst_restart: rows=%h sel=%b fs=%b, want 2a 110 1", rows, column_sel_n, frame_start);
        end
    endtask

    task automatic test_blank_period();
        int  dark;
        int  cyc;
        bit  seen;
        restart(7'h7F, 7'h7F, 7'h7F);
        dark = 0;
        cyc  = 0;
        seen = 1'b0;
        tick();
        for (int i = 1; i < 100 && !seen; i++) begin
            checks++;
            if ($countones(~column_sel_n) > 1) begin
                errors++;
                $display("FAIL one_hot cyc=%0d: sel=%b", i, column_sel_n);
            end
            if (column_sel_n === 3'b111) begin
                dark++;
                checks++;
                if (rows !== 7'h00) begin
                    errors++;
                    $display("FAIL blank_rows cyc=%0d: rows=%h, want 00", i, rows);
                end
            end
            if (frame_start === 1'b1) begin
                seen = 1'b1;
                cyc  = i;
            end else begin
                tick();
            end
        end
        checks++;
        if (!seen || cyc !== PERIOD) begin
            errors++;
            $display("FAIL blank_period: seen=%0b cycles=%0d, want %0d", seen, cyc, PERIOD);
        end
        checks++;
        if (dark !== 3 * NB) begin
            errors++;
            $display("FAIL blank_count: dark=%0d, want %0d", dark, 3 * NB);
        end
    endtask

    initial begin
        test_reset();
        test_scan();
        test_midframe_latch();
        test_enable_drop();
        test_async_reset();
        test_blank_period();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
